fwd_hazard_unit: RTL

- Parametrised operand forwarding and hazard unit for the pipelined core.
- Sits between decode and execute. It selects each source operand from the register file, the EX/MEM result or the MEM/WB result.
- Detects load-use hazards and stalls for a configurable load latency.
- Freezes forwarded operands across memory-induced pipeline stalls so a retiring writeback cannot corrupt a stalled consumer. This generalises the fixed two-operand, 16-bit, single-stall forwarding logic.

---
 rtl/fwd_hazard_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use interlock and stall-freeze for the
// decode/execute boundary of the pipelined core.
module fwd_hazard_unit #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 3,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_HW = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*DATA_W-1:0] rf_data,
  input  logic                      ex_wr_en,
  input  logic [REG_AW-1:0]         ex_wr_addr,
  input  logic                      ex_is_load,
  input  logic [DATA_W-1:0]         ex_data,
  input  logic                      wb_wr_en,
  input  logic [REG_AW-1:0]         wb_wr_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      pipe_stall,
  input  logic                      flush,
  output logic [NUM_SRC*DATA_W-1:0] op_data,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      load_use_stall,
  output logic                      err
);

  localparam logic [3:0] LAT = 4'(LOAD_LAT);
  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_EX   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                    state;
  state_t                    stateNext;
  logic [3:0]                luCnt;
  logic [3:0]                luCntNext;
  logic [NUM_SRC-1:0]        zeroSrc;
  logic [NUM_SRC-1:0]        exHit;
  logic [NUM_SRC-1:0]        wbHit;
  logic                      detect;
  logic                      holdValid;
  logic [NUM_SRC*DATA_W-1:0] holdData;
  logic                      errSet;
  logic                      errQ;

  // Per-port producer match; register 0 never matches when hardwired
  always_comb begin
    zeroSrc = '0;
    exHit   = '0;
    wbHit   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      zeroSrc[i] = (ZERO_REG_HW != 0) &&
                   (src_addr[i*REG_AW +: REG_AW] == '0);
      exHit[i] = src_used[i] & ex_wr_en & ~zeroSrc[i] &
                 (ex_wr_addr == src_addr[i*REG_AW +: REG_AW]);
      wbHit[i] = src_used[i] & wb_wr_en & ~zeroSrc[i] &
                 (wb_wr_addr == src_addr[i*REG_AW +: REG_AW]);
    end
  end

  // Operand mux: held value beats EX (non-load) beats WB beats RF
  always_comb begin
    op_data = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (holdValid) begin
        op_data[i*DATA_W +: DATA_W] = holdData[i*DATA_W +: DATA_W];
        fwd_sel[i*2 +: 2]           = SEL_HOLD;
      end else if (zeroSrc[i]) begin
        op_data[i*DATA_W +: DATA_W] = '0;
        fwd_sel[i*2 +: 2]           = SEL_RF;
      end else if (exHit[i] && !ex_is_load) begin
        op_data[i*DATA_W +: DATA_W] = ex_data;
        fwd_sel[i*2 +: 2]           = SEL_EX;
      end else if (wbHit[i]) begin
        op_data[i*DATA_W +: DATA_W] = wb_data;
        fwd_sel[i*2 +: 2]           = SEL_WB;
      end else begin
        op_data[i*DATA_W +: DATA_W] = rf_data[i*DATA_W +: DATA_W];
        fwd_sel[i*2 +: 2]           = SEL_RF;
      end
    end
  end

  // Freeze operands on the first stalled edge so retiring WB can't leak in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdValid <= 1'b0;
      holdData  <= '0;
    end else if (flush || !pipe_stall) begin
      holdValid <= 1'b0;
    end else if (!holdValid) begin
      holdValid <= 1'b1;
      holdData  <= op_data;
    end
  end

  // Load-use FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      luCnt <= '0;
    end else begin
      state <= stateNext;
      luCnt <= luCntNext;
    end
  end

  // Load-use FSM next state; the wait count only advances when the pipe moves
  always_comb begin
    stateNext = state;
    luCntNext = luCnt;
    if (flush) begin
      stateNext = S_IDLE;
      luCntNext = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (detect && LOAD_LAT > 1) begin
            stateNext = S_WAIT;
            luCntNext = LAT - 4'd1;
          end
        end
        S_WAIT: begin
          if (!pipe_stall) begin
            luCntNext = luCnt - 4'd1;
            if (luCnt == 4'd1) stateNext = S_IDLE;
          end
        end
        default: begin
          stateNext = S_IDLE;
          luCntNext = '0;
        end
      endcase
    end
  end

  // Load-use FSM outputs; flush kills the bubble request that cycle
  always_comb begin
    detect         = (state == S_IDLE) & ex_is_load & (|exHit);
    load_use_stall = ~flush & ((state == S_WAIT) | detect);
  end

  // Sticky error flag for impossible control combinations
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) errQ <= 1'b0;
    else      errQ <= errQ | errSet;
  end

  // Illegal combinations sampled every cycle
  always_comb begin
    errSet = (ex_is_load & ~ex_wr_en) |
             ((state == S_WAIT) & (luCnt == 4'd0)) |
             (luCnt > LAT);
  end

  assign err = errQ;

endmodule
